// File: rtl/iso7816_t0_pkg.sv
// -----------------------------------------------------------------------------
// iso7816_t0_pkg
// Shared definitions for the ISO7816-3 T=0 TPDU monitor.
//   - t0State_t    : FSM state encoding of the TPDU tracker
//   - T0_NULL      : NULL procedure byte (0x60)
//   - HDR_*_LSB    : bit offsets of the header fields in the 40-bit header
//   - isSw1Class() : true for bytes that open a status word (0x6X X!=0, 0x9X)
// -----------------------------------------------------------------------------
package iso7816_t0_pkg;

    typedef enum logic [2:0] {
        ST_HDR      = 3'd0,
        ST_PROC     = 3'd1,
        ST_DATA_ALL = 3'd2,
        ST_DATA_ONE = 3'd3,
        ST_SW2      = 3'd4
    } t0State_t;

    localparam logic [7:0] T0_NULL = 8'h60;

    localparam int HDR_CLA_LSB = 32;
    localparam int HDR_INS_LSB = 24;
    localparam int HDR_P1_LSB  = 16;
    localparam int HDR_P2_LSB  = 8;
    localparam int HDR_P3_LSB  = 0;

    // 0x60 itself is the NULL byte and is excluded from the 0x6X class.
    function automatic logic isSw1Class(input logic [7:0] b);
        return ((b[7:4] == 4'h6) && (b[3:0] != 4'h0)) || (b[7:4] == 4'h9);
    endfunction

endpackage

// File: rtl/iso7816_t0_mon_ins_dir.sv
// -----------------------------------------------------------------------------
// iso7816_t0_ins_dir
// Combinational INS-to-direction lookup. Used by iso7816_t0_tpdu_monitor only
// when T0_MON_INS_TABLE_EN is defined.
// Ports:
//   ins       in  8 : instruction byte of the current header
//   cardSends out 1 : high when the listed INS means the card sends data
// -----------------------------------------------------------------------------
module iso7816_t0_ins_dir (
    input  logic [7:0] ins,
    output logic       cardSends
);

    always_comb begin
        cardSends = 1'b0;
        case (ins)
            8'hB0, 8'hB2, 8'hC0, 8'hCA, 8'h84, 8'h12, 8'hF2: cardSends = 1'b1;
            default:                                         cardSends = 1'b0;
        endcase
    end

endmodule

// File: rtl/iso7816_t0_tpdu_monitor.sv
// -----------------------------------------------------------------------------
// iso7816_t0_tpdu_monitor
// Passive T=0 command/response tracker. Consumes convention-corrected bytes
// after ATR completion and reports header, procedure handling, data phase,
// status word, direction hints and error statistics.
//
// Build option: T0_MON_INS_TABLE_EN
//   defined   : data direction derived from a built-in INS table
//   undefined : data direction = cardSendsData sampled when P3 is accepted
//
// Ports:
//   clk, reset (async, active high)
//   enable               : ATR done and T=0 selected; low forces HDR
//   rxValid/rxData/rxFrameError : byte strobe, byte, parity/frame error flag
//   cardSendsData        : direction hint sampled at P3
//   header[39:0]         : {CLA, INS, P1, P2, P3}
//   waitCardTx/waitTermTx: expected next sender
//   dataValid/dataByte/dataIdx : data-phase byte report (one-cycle)
//   sw1, sw2, tpduDone   : status word and end-of-TPDU pulse
//   protoError           : illegal procedure byte pulse
//   nullCnt, tpduCnt, frameErrCnt, protoErrCnt : statistics
// -----------------------------------------------------------------------------
module iso7816_t0_tpdu_monitor
    import iso7816_t0_pkg::*;
#(
    parameter int NULL_CNT_WIDTH = 8,
    parameter int TPDU_CNT_WIDTH = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      rxValid,
    input  logic [7:0]                rxData,
    input  logic                      rxFrameError,
    input  logic                      cardSendsData,
    output logic [39:0]               header,
    output logic                      waitCardTx,
    output logic                      waitTermTx,
    output logic                      dataValid,
    output logic [7:0]                dataByte,
    output logic [8:0]                dataIdx,
    output logic [7:0]                sw1,
    output logic [7:0]                sw2,
    output logic                      tpduDone,
    output logic                      protoError,
    output logic [NULL_CNT_WIDTH-1:0] nullCnt,
    output logic [TPDU_CNT_WIDTH-1:0] tpduCnt,
    output logic [ERR_CNT_WIDTH-1:0]  frameErrCnt,
    output logic [ERR_CNT_WIDTH-1:0]  protoErrCnt
);

    t0State_t   state;
    t0State_t   stateNext;
    logic [2:0] hdrIdx;
    logic [8:0] remaining;
    logic [8:0] idxCnt;
    logic       outgoing;
    logic       outgoingAtP3;
    logic       acceptByte;
    logic       protoErrNext;
    logic [7:0] insByte;
    logic [8:0] p3Remaining;

    assign insByte    = header[HDR_INS_LSB +: 8];
    assign acceptByte = enable && rxValid && !rxFrameError;

`ifdef T0_MON_INS_TABLE_EN
    // INS is already in the header register when P3 arrives.
    iso7816_t0_ins_dir insDir (
        .ins       (insByte),
        .cardSends (outgoingAtP3)
    );
`else
    assign outgoingAtP3 = cardSendsData;
`endif

    // P3 == 0 means 256 bytes only for card-to-terminal transfers.
    assign p3Remaining = ((rxData == 8'h00) && outgoingAtP3) ? 9'd256 : {1'b0, rxData};

    always_comb begin
        stateNext    = state;
        protoErrNext = 1'b0;
        if (!enable) begin
            stateNext = ST_HDR;
        end else if (acceptByte) begin
            case (state)
                ST_HDR: begin
                    if (hdrIdx == 3'd4) stateNext = ST_PROC;
                end
                ST_PROC: begin
                    if (rxData == T0_NULL) begin
                        stateNext = ST_PROC;
                    end else if (rxData == insByte || rxData == ~insByte) begin
                        if (remaining == 9'd0) begin
                            protoErrNext = 1'b1;
                            stateNext    = ST_HDR;
                        end else begin
                            stateNext = (rxData == insByte) ? ST_DATA_ALL : ST_DATA_ONE;
                        end
                    end else if (isSw1Class(rxData)) begin
                        stateNext = ST_SW2;
                    end else begin
                        protoErrNext = 1'b1;
                        stateNext    = ST_HDR;
                    end
                end
                ST_DATA_ALL: begin
                    if (remaining <= 9'd1) stateNext = ST_PROC;
                end
                ST_DATA_ONE: stateNext = ST_PROC;
                ST_SW2:      stateNext = ST_HDR;
                default:     stateNext = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_HDR;
            hdrIdx      <= 3'd0;
            remaining   <= 9'd0;
            idxCnt      <= 9'd0;
            outgoing    <= 1'b0;
            header      <= 40'd0;
            waitCardTx  <= 1'b0;
            waitTermTx  <= 1'b0;
            dataValid   <= 1'b0;
            dataByte    <= 8'd0;
            dataIdx     <= 9'd0;
            sw1         <= 8'd0;
            sw2         <= 8'd0;
            tpduDone    <= 1'b0;
            protoError  <= 1'b0;
            nullCnt     <= '0;
            tpduCnt     <= '0;
            frameErrCnt <= '0;
            protoErrCnt <= '0;
        end else begin
            state      <= stateNext;
            dataValid  <= 1'b0;
            tpduDone   <= 1'b0;
            protoError <= protoErrNext;

            // Direction hints follow the state being entered, so they are
            // valid in the same cycle as the other byte-driven outputs.
            waitTermTx <= enable && ((stateNext == ST_HDR) ||
                          (((stateNext == ST_DATA_ALL) || (stateNext == ST_DATA_ONE)) && !outgoing));
            waitCardTx <= enable && ((stateNext == ST_PROC) || (stateNext == ST_SW2) ||
                          (((stateNext == ST_DATA_ALL) || (stateNext == ST_DATA_ONE)) && outgoing));

            if (!enable) begin
                hdrIdx <= 3'd0;
            end else if (rxValid && rxFrameError) begin
                // The card repeats an erroneous byte, so nothing advances.
                if (frameErrCnt != '1) frameErrCnt <= frameErrCnt + 1'b1;
            end else if (rxValid) begin
                case (state)
                    ST_HDR: begin
                        case (hdrIdx)
                            3'd0:    header[HDR_CLA_LSB +: 8] <= rxData;
                            3'd1:    header[HDR_INS_LSB +: 8] <= rxData;
                            3'd2:    header[HDR_P1_LSB  +: 8] <= rxData;
                            3'd3:    header[HDR_P2_LSB  +: 8] <= rxData;
                            default: header[HDR_P3_LSB  +: 8] <= rxData;
                        endcase
                        if (hdrIdx == 3'd4) begin
                            hdrIdx    <= 3'd0;
                            remaining <= p3Remaining;
                            outgoing  <= outgoingAtP3;
                            nullCnt   <= '0;
                            idxCnt    <= 9'd0;
                        end else begin
                            hdrIdx <= hdrIdx + 3'd1;
                        end
                    end
                    ST_PROC: begin
                        if (rxData == T0_NULL) begin
                            if (nullCnt != '1) nullCnt <= nullCnt + 1'b1;
                        end else if (protoErrNext) begin
                            if (protoErrCnt != '1) protoErrCnt <= protoErrCnt + 1'b1;
                        end else if (stateNext == ST_SW2) begin
                            sw1 <= rxData;
                        end
                    end
                    ST_DATA_ALL, ST_DATA_ONE: begin
                        dataValid <= 1'b1;
                        dataByte  <= rxData;
                        dataIdx   <= idxCnt;
                        idxCnt    <= idxCnt + 9'd1;
                        remaining <= remaining - 9'd1;
                    end
                    ST_SW2: begin
                        sw2      <= rxData;
                        tpduDone <= 1'b1;
                        tpduCnt  <= tpduCnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iso7816_t0_tpdu_monitor.sv
module tb_iso7816_t0_tpdu_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        rxFrameError;
    logic        cardSendsData;
    logic [39:0] header;
    logic        waitCardTx, waitTermTx;
    logic        dataValid;
    logic [7:0]  dataByte;
    logic [8:0]  dataIdx;
    logic [7:0]  sw1, sw2;
    logic        tpduDone, protoError;
    logic [7:0]  nullCnt;
    logic [15:0] tpduCnt;
    logic [7:0]  frameErrCnt, protoErrCnt;

    int total = 0;
    int bad   = 0;

    // Monitor-side pulse bookkeeping (only written here).
    int         dvCount   = 0;
    int         doneCount = 0;
    int         perrCount = 0;
    logic [8:0] idxLog  [0:1023];
    logic [7:0] byteLog [0:1023];

    always #5 clk = ~clk;

    iso7816_t0_tpdu_monitor #(
        .NULL_CNT_WIDTH (8),
        .TPDU_CNT_WIDTH (16),
        .ERR_CNT_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rxValid       (rxValid),
        .rxData        (rxData),
        .rxFrameError  (rxFrameError),
        .cardSendsData (cardSendsData),
        .header        (header),
        .waitCardTx    (waitCardTx),
        .waitTermTx    (waitTermTx),
        .dataValid     (dataValid),
        .dataByte      (dataByte),
        .dataIdx       (dataIdx),
        .sw1           (sw1),
        .sw2           (sw2),
        .tpduDone      (tpduDone),
        .protoError    (protoError),
        .nullCnt       (nullCnt),
        .tpduCnt       (tpduCnt),
        .frameErrCnt   (frameErrCnt),
        .protoErrCnt   (protoErrCnt)
    );

    always @(negedge clk) begin
        if (dataValid) begin
            if (dvCount < 1024) begin
                idxLog[dvCount]  <= dataIdx;
                byteLog[dvCount] <= dataByte;
            end
            dvCount <= dvCount + 1;
        end
        if (tpduDone)   doneCount <= doneCount + 1;
        if (protoError) perrCount <= perrCount + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consecutive calls give back-to-back rxValid cycles.
    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        rxValid = 1'b1; rxData = b; rxFrameError = 1'b0;
    endtask

    task automatic sendBad(input logic [7:0] b);
        @(negedge clk);
        rxValid = 1'b1; rxData = b; rxFrameError = 1'b1;
    endtask

    // Ends a burst; returns 1 ns after the negedge following the last byte.
    task automatic endTx();
        @(negedge clk);
        rxValid = 1'b0; rxFrameError = 1'b0;
        #1;
    endtask

    task automatic sendHeader(input logic [7:0] cla, input logic [7:0] ins,
                              input logic [7:0] p1, input logic [7:0] p2,
                              input logic [7:0] p3);
        sendByte(cla); sendByte(ins); sendByte(p1); sendByte(p2); sendByte(p3);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; rxValid = 1'b0; rxData = 8'h00;
        rxFrameError = 1'b0; cardSendsData = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (header !== 40'd0) begin bad++; $display("FAIL reset_header got=%h exp=0", header); end
        total++; if ({sw1, sw2} !== 16'h0000) begin bad++; $display("FAIL reset_sw got=%h exp=0000", {sw1, sw2}); end
        total++; if ({waitCardTx, waitTermTx, dataValid, tpduDone, protoError} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {waitCardTx, waitTermTx, dataValid, tpduDone, protoError}); end
        total++; if ({nullCnt, tpduCnt, frameErrCnt, protoErrCnt} !== 40'd0) begin
            bad++; $display("FAIL reset_counters got=%h exp=0", {nullCnt, tpduCnt, frameErrCnt, protoErrCnt}); end
        @(negedge clk);
        reset = 1'b0; enable = 1'b1;
        @(negedge clk); #1;
        total++; if ({waitCardTx, waitTermTx} !== 2'b01) begin
            bad++; $display("FAIL reset_idle_dir got=%b exp=01", {waitCardTx, waitTermTx}); end
        $display("[tb] reset done");
    endtask

    task automatic test_case2();
        int dv0 = dvCount, dn0 = doneCount;
        cardSendsData = 1'b1;
        sendHeader(8'h00, 8'hB0, 8'h00, 8'h00, 8'h02);
        endTx();
        total++; if (header !== 40'h00B0000002) begin bad++; $display("FAIL c2_header got=%h exp=00b0000002", header); end
        total++; if ({waitCardTx, waitTermTx} !== 2'b10) begin bad++; $display("FAIL c2_proc_dir got=%b exp=10", {waitCardTx, waitTermTx}); end
        sendByte(8'hB0);
        endTx();
        total++; if ({waitCardTx, waitTermTx} !== 2'b10) begin bad++; $display("FAIL c2_data_dir got=%b exp=10", {waitCardTx, waitTermTx}); end
        sendByte(8'hAA); sendByte(8'hBB); sendByte(8'h90); sendByte(8'h00);
        endTx();
        total++; if (dvCount - dv0 !== 2) begin bad++; $display("FAIL c2_dv_count got=%0d exp=2", dvCount - dv0); end
        total++; if ({idxLog[dv0], idxLog[dv0+1]} !== {9'd0, 9'd1}) begin
            bad++; $display("FAIL c2_idx got=%0d,%0d exp=0,1", idxLog[dv0], idxLog[dv0+1]); end
        total++; if ({byteLog[dv0], byteLog[dv0+1]} !== 16'hAABB) begin
            bad++; $display("FAIL c2_bytes got=%h%h exp=aabb", byteLog[dv0], byteLog[dv0+1]); end
        total++; if ({sw1, sw2} !== 16'h9000) begin bad++; $display("FAIL c2_sw got=%h exp=9000", {sw1, sw2}); end
        total++; if (doneCount - dn0 !== 1) begin bad++; $display("FAIL c2_done_pulses got=%0d exp=1", doneCount - dn0); end
        total++; if (tpduCnt !== 16'd1) begin bad++; $display("FAIL c2_tpdu_cnt got=%0d exp=1", tpduCnt); end
        total++; if ({waitCardTx, waitTermTx} !== 2'b01) begin bad++; $display("FAIL c2_hdr_dir got=%b exp=01", {waitCardTx, waitTermTx}); end
        $display("[tb] case2 READ BINARY done");
    endtask

    task automatic test_case3();
        int dv0 = dvCount, dn0 = doneCount;
        cardSendsData = 1'b0;
        sendHeader(8'h00, 8'hD6, 8'h00, 8'h00, 8'h02);
        sendByte(8'h29);
        endTx();
        total++; if ({waitCardTx, waitTermTx} !== 2'b01) begin bad++; $display("FAIL c3_data_dir1 got=%b exp=01", {waitCardTx, waitTermTx}); end
        sendByte(8'h11); sendByte(8'h29);
        endTx();
        total++; if ({waitCardTx, waitTermTx} !== 2'b01) begin bad++; $display("FAIL c3_data_dir2 got=%b exp=01", {waitCardTx, waitTermTx}); end
        sendByte(8'h22); sendByte(8'h90); sendByte(8'h00);
        endTx();
        total++; if (dvCount - dv0 !== 2) begin bad++; $display("FAIL c3_dv_count got=%0d exp=2", dvCount - dv0); end
        total++; if ({byteLog[dv0], byteLog[dv0+1], idxLog[dv0], idxLog[dv0+1]} !== {8'h11, 8'h22, 9'd0, 9'd1}) begin
            bad++; $display("FAIL c3_data got=%h,%h idx %0d,%0d exp=11,22 idx 0,1",
                            byteLog[dv0], byteLog[dv0+1], idxLog[dv0], idxLog[dv0+1]); end
        total++; if (doneCount - dn0 !== 1) begin bad++; $display("FAIL c3_done_pulses got=%0d exp=1", doneCount - dn0); end
        total++; if (tpduCnt !== 16'd2) begin bad++; $display("FAIL c3_tpdu_cnt got=%0d exp=2", tpduCnt); end
        $display("[tb] case3 UPDATE BINARY done");
    endtask

    task automatic test_p3_zero();
        int dv0 = dvCount;
        int idxErr = 0;
        cardSendsData = 1'b1;
        sendHeader(8'h00, 8'hC0, 8'h00, 8'h00, 8'h00);
        sendByte(8'hC0);
        for (int i = 0; i < 256; i++) sendByte(8'(i ^ 8'h5A));
        endTx();
        total++; if (dvCount - dv0 !== 256) begin bad++; $display("FAIL p3z_dv_count got=%0d exp=256", dvCount - dv0); end
        total++; if (idxLog[dv0+255] !== 9'd255) begin bad++; $display("FAIL p3z_last_idx got=%0d exp=255", idxLog[dv0+255]); end
        for (int i = 0; i < 256; i++)
            if (idxLog[dv0+i] !== 9'(i) || byteLog[dv0+i] !== 8'(i ^ 8'h5A)) idxErr++;
        total++; if (idxErr !== 0) begin bad++; $display("FAIL p3z_sequence got=%0d bad entries exp=0", idxErr); end
        total++; if ({waitCardTx, waitTermTx} !== 2'b10) begin bad++; $display("FAIL p3z_back_in_proc got=%b exp=10", {waitCardTx, waitTermTx}); end
        sendByte(8'h90); sendByte(8'h00);
        endTx();
        total++; if (tpduCnt !== 16'd3) begin bad++; $display("FAIL p3z_tpdu_cnt got=%0d exp=3", tpduCnt); end
        $display("[tb] P3=00 GET RESPONSE 256 bytes done");
    endtask

    task automatic test_null();
        cardSendsData = 1'b0;
        sendHeader(8'h00, 8'hA4, 8'h00, 8'h00, 8'h02);
        sendByte(8'h60); sendByte(8'h60); sendByte(8'h60);
        sendByte(8'h6C); sendByte(8'h10);
        endTx();
        total++; if (nullCnt !== 8'd3) begin bad++; $display("FAIL null_cnt got=%0d exp=3", nullCnt); end
        total++; if ({sw1, sw2} !== 16'h6C10) begin bad++; $display("FAIL null_sw got=%h exp=6c10", {sw1, sw2}); end
        total++; if (tpduCnt !== 16'd4) begin bad++; $display("FAIL null_tpdu_cnt got=%0d exp=4", tpduCnt); end
        $display("[tb] NULL bytes + 6C10 done");
    endtask

    task automatic test_proto_error();
        int pe0 = perrCount;
        cardSendsData = 1'b0;
        sendHeader(8'h00, 8'hA4, 8'h04, 8'h00, 8'h02);
        sendByte(8'h42);
        endTx();
        total++; if (perrCount - pe0 !== 1) begin bad++; $display("FAIL perr_pulses got=%0d exp=1", perrCount - pe0); end
        total++; if (protoErrCnt !== 8'd1) begin bad++; $display("FAIL perr_cnt got=%0d exp=1", protoErrCnt); end
        total++; if ({waitCardTx, waitTermTx} !== 2'b01) begin bad++; $display("FAIL perr_to_hdr got=%b exp=01", {waitCardTx, waitTermTx}); end
        // Incoming P3=0 leaves nothing to transfer, so an ACK is illegal.
        sendHeader(8'h00, 8'hD6, 8'h00, 8'h00, 8'h00);
        sendByte(8'hD6);
        endTx();
        total++; if (perrCount - pe0 !== 2) begin bad++; $display("FAIL perr_ack_zero got=%0d exp=2", perrCount - pe0); end
        total++; if (header !== 40'h00D6000000) begin bad++; $display("FAIL perr_header got=%h exp=00d6000000", header); end
        $display("[tb] protocol errors done");
    endtask

    task automatic test_frame_error();
        int dv0 = dvCount;
        cardSendsData = 1'b1;
        sendHeader(8'h00, 8'hB0, 8'h00, 8'h00, 8'h02);
        sendByte(8'hB0); sendByte(8'hAA); sendBad(8'hBB); sendByte(8'hBB);
        sendByte(8'h90); sendByte(8'h00);
        endTx();
        total++; if (frameErrCnt !== 8'd1) begin bad++; $display("FAIL ferr_cnt got=%0d exp=1", frameErrCnt); end
        total++; if (dvCount - dv0 !== 2) begin bad++; $display("FAIL ferr_dv_count got=%0d exp=2", dvCount - dv0); end
        total++; if ({byteLog[dv0+1], idxLog[dv0+1]} !== {8'hBB, 9'd1}) begin
            bad++; $display("FAIL ferr_repeat got=%h idx %0d exp=bb idx 1", byteLog[dv0+1], idxLog[dv0+1]); end
        total++; if (tpduCnt !== 16'd5) begin bad++; $display("FAIL ferr_tpdu_cnt got=%0d exp=5", tpduCnt); end
        $display("[tb] frame error repeat done");
    endtask

    task automatic test_enable_drop();
        int dv0 = dvCount;
        cardSendsData = 1'b1;
        sendHeader(8'h00, 8'hB0, 8'h00, 8'h00, 8'h04);
        sendByte(8'hB0); sendByte(8'h11); sendByte(8'h22);
        // Byte arriving with enable falling is dropped.
        @(negedge clk);
        enable = 1'b0; rxValid = 1'b1; rxData = 8'h33; rxFrameError = 1'b0;
        endTx();
        total++; if ({waitCardTx, waitTermTx} !== 2'b00) begin bad++; $display("FAIL en_dir_off got=%b exp=00", {waitCardTx, waitTermTx}); end
        total++; if (dvCount - dv0 !== 2) begin bad++; $display("FAIL en_dropped got=%0d exp=2", dvCount - dv0); end
        enable = 1'b1;
        @(negedge clk); #1;
        total++; if ({waitCardTx, waitTermTx} !== 2'b01) begin bad++; $display("FAIL en_dir_back got=%b exp=01", {waitCardTx, waitTermTx}); end
        sendHeader(8'h00, 8'hB0, 8'h00, 8'h00, 8'h01);
        sendByte(8'hB0); sendByte(8'h5A); sendByte(8'h90); sendByte(8'h00);
        endTx();
        total++; if (dvCount - dv0 !== 3) begin bad++; $display("FAIL en_next_dv got=%0d exp=3", dvCount - dv0); end
        total++; if ({byteLog[dv0+2], idxLog[dv0+2]} !== {8'h5A, 9'd0}) begin
            bad++; $display("FAIL en_next_data got=%h idx %0d exp=5a idx 0", byteLog[dv0+2], idxLog[dv0+2]); end
        total++; if ({sw1, sw2, tpduCnt} !== {8'h90, 8'h00, 16'd6}) begin
            bad++; $display("FAIL en_next_sw got=%h%h cnt %0d exp=9000 cnt 6", sw1, sw2, tpduCnt); end
        $display("[tb] enable drop + recovery done");
    endtask

    initial begin
        test_reset();
        test_case2();
        test_case3();
        test_p3_zero();
        test_null();
        test_proto_error();
        test_frame_error();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iso7816_t0_tpdu_monitor.md
# iso7816_t0_tpdu_monitor

Passive, parametrised T=0 command/response monitor that follows the ATR analysis stage in the ISO7816-3 analyzer chain. It consumes decoded, convention-corrected bytes from the receive core after the ATR has completed and tracks the TPDU protocol. It reports the header, procedure bytes, the data phase with direction, the status word, and error and retransmission statistics. It supplies the `waitCardTx`/`waitTermTx` direction hints that the direction/error-signal logic consumes.

## Interface
- `NULL_CNT_WIDTH`, 8: width of the saturating NULL (0x60) counter per TPDU.
- `TPDU_CNT_WIDTH`, 16: width of the wrapping completed-TPDU counter.
- `ERR_CNT_WIDTH`, 8: width of the saturating frame-error and protocol-error counters.
- `clk` in 1: single clock (ISO clock domain); everything registered on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `enable` in 1: high when ATR is completed and T=0 is selected; low forces the FSM to HDR synchronously.
- `rxValid` in 1: one-cycle strobe; a received byte is present.
- `rxData` in 8: received byte, already in direct convention.
- `rxFrameError` in 1: qualifies `rxValid`; the byte had a parity or frame error.
- `cardSendsData` in 1: direction hint, sampled when P3 is accepted (used only without the macro).
- `header` out 40: {CLA, INS, P1, P2, P3}, with CLA in [39:32].
- `waitCardTx`, `waitTermTx` out 1 each: expected next sender.
- `dataValid` out 1, `dataByte` out 8, `dataIdx` out 9: one-cycle data-phase byte report.
- `sw1`, `sw2` out 8 each: last status word.
- `tpduDone` out 1: one-cycle pulse after SW2.
- `protoError` out 1: one-cycle pulse on an illegal procedure byte.
- `nullCnt` out NULL_CNT_WIDTH; `tpduCnt` out TPDU_CNT_WIDTH; `frameErrCnt`, `protoErrCnt` out ERR_CNT_WIDTH.

## Operation
- FSM states:
  - HDR: collects bytes 0..4 into `header`. On P3, sets `remaining` = 256 if P3==0 and outgoing, else P3. Clears `nullCnt` and the data index. Goes to PROC.
  - PROC:
    - 0x60: `nullCnt`++ (saturating), stay in PROC.
    - Byte == INS: go to DATA_ALL.
    - Byte == INS^0xFF: go to DATA_ONE.
    - 0x6X (X≠0) or 0x9X: store `sw1`, go to SW2.
    - Any other byte: `protoError` pulse, `protoErrCnt`++, go to HDR.
    - ACK or ~ACK while `remaining`==0: `protoError` pulse, go to HDR.
  - DATA_ALL: on each byte, `dataValid` pulses and `remaining`--. Returns to PROC when `remaining` reaches 0.
  - DATA_ONE: one byte, `remaining`--, back to PROC.
  - SW2: stores `sw2`, pulses `tpduDone`, `tpduCnt`++ (wrapping), goes to HDR.
- Direction flag `outgoing` (card sends data) is latched at P3 acceptance.
- Direction outputs:
  - HDR: `waitTermTx`=1, `waitCardTx`=0.
  - PROC and SW2: `waitCardTx`=1, `waitTermTx`=0.
  - DATA_ALL and DATA_ONE: `waitCardTx`=`outgoing`, `waitTermTx`=~`outgoing`.
  - `enable` low: both 0.
- Frame errors: `rxValid`&`rxFrameError` discards the byte and increments `frameErrCnt` (saturating). State and `remaining` are held, because T=0 repeats the byte.
- `remaining` is 9 bits. `dataIdx` counts 0..remaining_initial-1 and never wraps inside one TPDU.

## Timing
- Every output is registered. An output reflects an accepted byte one cycle after its `rxValid`.
- `dataValid`, `tpduDone` and `protoError` are exactly one cycle wide.
- `rxValid` together with `enable` falling in the same cycle: `enable` wins, the byte is dropped, and the FSM goes to HDR.
- Reset values:
  - Multi-bit outputs and counters: 0.
  - Pulses and direction flags: 0.
  - `sw1`, `sw2`: 0.
- Back-to-back `rxValid` on consecutive cycles must be accepted with no loss.

## Configuration
- `T0_MON_INS_TABLE_EN`:
  - Defined: `outgoing` is taken from a built-in INS table: 0xB0, 0xB2, 0xC0, 0xCA, 0x84, 0x12, 0xF2. A listed INS means the card sends data. `cardSendsData` is ignored.
  - Undefined: `outgoing` = `cardSendsData` sampled at P3 acceptance.

## Structure
- Shared package `iso7816_t0_pkg`:
  - FSM state encoding.
  - `T0_NULL`=8'h60.
  - Header field bit offsets.
  - SW1 class mask function.
- Sub-module `iso7816_t0_ins_dir`: combinational INS-to-direction lookup. It is instantiated only under `T0_MON_INS_TABLE_EN`.

## Test plan
- Case 2 READ BINARY (00 B0 00 00 02), then ACK B0, data AA BB, then 90 00:
  - Two `dataValid` pulses, with idx 0 and 1.
  - `sw1`/`sw2`=90/00.
  - `tpduDone` pulses once; `tpduCnt`=1.
  - `waitCardTx` high during data.
- Case 3 (00 D6 00 00 02, `cardSendsData`=0), then procedure bytes 29, 11, 29, 22, then 90 00:
  - Two DATA_ONE transfers.
  - `waitTermTx` high during data.
  - `tpduDone` pulses once.
- Header with P3=00 and outgoing INS C0, then ACK: 256 `dataValid` pulses, with the last `dataIdx`=255, then return to PROC.
- Procedure bytes 60 60 60, then 6C 10: `nullCnt`=3, `sw1`=6C, `sw2`=10.
- After the header, byte 0x42 in PROC: `protoError` pulses, `protoErrCnt`=1, FSM in HDR.
- Frame error on the 2nd data byte, followed by its repeat:
  - `frameErrCnt`=1.
  - Exactly 2 `dataValid` pulses in total.
- `enable` dropped mid-DATA_ALL: both direction flags go to 0 and the next TPDU is decoded correctly.
